// File: rtl/sc_fifo.sv
// Single-clock FIFO on a synchronous-read RAM, normal (non-showahead) read mode.
// Over/underflow protected; sclr empties the buffer without touching RAM contents.
module sc_fifo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 256,
    parameter int WIDTHU = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sclr,
    input  logic [WIDTH-1:0]  data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [WIDTH-1:0]  q,
    output logic              empty,
    output logic              full,
    output logic [WIDTHU-1:0] usedw
);
    localparam logic [WIDTHU:0] FULL_CNT = (WIDTHU+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTHU-1:0] wr_ptr;
    logic [WIDTHU-1:0] rd_ptr;
    logic [WIDTHU:0]   count;
    logic              wr_ok;
    logic              rd_ok;

    // Flags come straight from the count register, so no input reaches an output combinationally.
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign usedw = count[WIDTHU-1:0];

    assign wr_ok = wrreq & ~full  & ~sclr;
    assign rd_ok = rdreq & ~empty & ~sclr;

    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[wr_ptr] <= data;
    end

    // Pointers wrap for free because DEPTH == 2**WIDTHU.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q      <= '0;
        end else if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q      <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                q      <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_fifo.sv
// Self-checking bench for sc_fifo against a queue-based reference model.
module tb_sc_fifo;
    localparam int WIDTH  = 64;
    localparam int DEPTH  = 256;
    localparam int WIDTHU = 8;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              sclr;
    logic [WIDTH-1:0]  data;
    logic              wrreq;
    logic              rdreq;
    logic [WIDTH-1:0]  q;
    logic              empty;
    logic              full;
    logic [WIDTHU-1:0] usedw;

    always #5 clock = ~clock;

    sc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WIDTHU(WIDTHU)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sclr    (sclr),
        .data    (data),
        .wrreq   (wrreq),
        .rdreq   (rdreq),
        .q       (q),
        .empty   (empty),
        .full    (full),
        .usedw   (usedw)
    );

    // Reference model: stored words in order plus the last value presented on q.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_q;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [WIDTH+WIDTHU+1:0] model_state();
        return {m_q, mq.size() == 0, mq.size() == DEPTH, WIDTHU'(mq.size())};
    endfunction

    function automatic logic [WIDTH:0] rnd64();
        return {1'b0, $urandom, $urandom};
    endfunction

    // Drive one clock of stimulus (entered just after an edge), advance the model, settle 1 time unit.
    task automatic cycle(input logic s, input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit do_wr;
        bit do_rd;
        sclr = s; wrreq = w; rdreq = r; data = d;
        do_wr = w && (mq.size() < DEPTH);
        do_rd = r && (mq.size() > 0);
        @(posedge clock);
        if (s) begin
            mq.delete();
            m_q = '0;
        end else begin
            if (do_rd) m_q = mq.pop_front();
            if (do_wr) mq.push_back(d);
        end
        #1;
        sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0;
        mq.delete(); m_q = '0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({q, empty, full, usedw} !== {{WIDTH{1'b0}}, 1'b1, 1'b0, {WIDTHU{1'b0}}}) begin
            n_bad++; $display("FAIL reset_hold: got q=%h e=%b f=%b u=%0d want q=0 e=1 f=0 u=0", q, empty, full, usedw);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            n_cmp++;
            if ({q, empty, full, usedw} !== {{WIDTH{1'b0}}, 1'b1, 1'b0, {WIDTHU{1'b0}}}) begin
                n_bad++; $display("FAIL reset_idle_rd%0d: got q=%h e=%b u=%0d want q=0 e=1 u=0", i, q, empty, usedw);
            end
        end
    endtask

    task automatic test_ordered();
        logic [WIDTH-1:0] exp_w [3];
        exp_w[0] = 'h11; exp_w[1] = 'h22; exp_w[2] = 'h33;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, exp_w[i]);
        n_cmp++;
        if (usedw !== 8'd3 || empty !== 1'b0) begin
            n_bad++; $display("FAIL ordered_count: got u=%0d e=%b want u=3 e=0", usedw, empty);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            n_cmp++;
            if (q !== exp_w[i]) begin
                n_bad++; $display("FAIL ordered_q%0d: got %h want %h", i, q, exp_w[i]);
            end
        end
        n_cmp++;
        if (usedw !== 8'd0 || empty !== 1'b1) begin
            n_bad++; $display("FAIL ordered_drain: got u=%0d e=%b want u=0 e=1", usedw, empty);
        end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] q_before;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, WIDTH'(i));
        n_cmp++;
        if (full !== 1'b1 || usedw !== 8'd0 || empty !== 1'b0) begin
            n_bad++; $display("FAIL fill_full: got f=%b u=%0d e=%b want f=1 u=0 e=0", full, usedw, empty);
        end
        q_before = m_q;
        cycle(1'b0, 1'b1, 1'b0, 'hDEAD);
        n_cmp++;
        if ({q, empty, full, usedw} !== {q_before, 1'b0, 1'b1, 8'd0}) begin
            n_bad++; $display("FAIL fill_overflow: got q=%h f=%b u=%0d want q=%h f=1 u=0", q, full, usedw, q_before);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            n_cmp++;
            if (q !== WIDTH'(i)) begin
                n_bad++; $display("FAIL fill_read%0d: got %h want %h", i, q, WIDTH'(i));
            end
        end
        n_cmp++;
        if (empty !== 1'b1 || usedw !== 8'd0) begin
            n_bad++; $display("FAIL fill_empty: got e=%b u=%0d want e=1 u=0", empty, usedw);
        end
    endtask

    task automatic test_boundary();
        logic [WIDTH-1:0] q_before;
        logic [WIDTH-1:0] oldest;
        logic [WIDTH-1:0] bad_w;
        // Empty: write proceeds, read is dropped, no bypass.
        q_before = m_q;
        cycle(1'b0, 1'b1, 1'b1, 'h5);
        n_cmp++;
        if ({q, empty, usedw} !== {q_before, 1'b0, 8'd1}) begin
            n_bad++; $display("FAIL empty_wr_rd: got q=%h e=%b u=%0d want q=%h e=0 u=1", q, empty, usedw, q_before);
        end
        cycle(1'b0, 1'b0, 1'b1, '0);
        n_cmp++;
        if (q !== 'h5) begin
            n_bad++; $display("FAIL empty_wr_rd_next: got %h want 5", q);
        end
        // Full: read proceeds, write is dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, rnd64());
        oldest = mq[0];
        bad_w  = 64'hBAD0_BAD0_BAD0_BAD0;
        cycle(1'b0, 1'b1, 1'b1, bad_w);
        n_cmp++;
        if ({q, full, usedw} !== {oldest, 1'b0, 8'd255}) begin
            n_bad++; $display("FAIL full_wr_rd: got q=%h f=%b u=%0d want q=%h f=0 u=255", q, full, usedw, oldest);
        end
        while (mq.size() > 0) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            n_cmp++;
            if (q !== m_q || q === bad_w) begin
                n_bad++; $display("FAIL full_drain: got %h want %h", q, m_q);
            end
        end
        // Mid-occupancy: simultaneous traffic holds the count.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, rnd64());
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, rnd64());
            n_cmp++;
            if ({q, usedw} !== {m_q, 8'd10}) begin
                n_bad++; $display("FAIL mid_wr_rd%0d: got q=%h u=%0d want q=%h u=10", i, q, usedw, m_q);
            end
        end
        while (mq.size() > 0) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            n_cmp++;
            if ({q, empty, full, usedw} !== model_state()) begin
                n_bad++; $display("FAIL mid_drain: got q=%h u=%0d want q=%h u=%0d", q, usedw, m_q, mq.size());
            end
        end
    endtask

    task automatic test_wrap();
        int  writes = 0;
        bit  w;
        bit  r;
        for (int it = 0; it < 5000 && (writes < 600 || mq.size() > 0); it++) begin
            if (writes >= 600) begin
                w = 1'b0; r = 1'b1;
            end else if (mq.size() <= 1) begin
                w = 1'b1; r = (mq.size() == 1) && ($urandom_range(0, 1) == 1);
            end else if (mq.size() >= 20) begin
                w = 1'b0; r = 1'b1;
            end else begin
                w = ($urandom_range(0, 2) != 0); r = ($urandom_range(0, 2) != 0);
            end
            if (w) writes++;
            cycle(1'b0, w, r, rnd64());
            n_cmp++;
            if ({q, empty, full, usedw} !== model_state()) begin
                n_bad++; $display("FAIL wrap_it%0d: got q=%h u=%0d want q=%h u=%0d", it, q, usedw, m_q, mq.size());
            end
        end
        n_cmp++;
        if (empty !== 1'b1 || usedw !== 8'd0) begin
            n_bad++; $display("FAIL wrap_end: got e=%b u=%0d want e=1 u=0", empty, usedw);
        end
    endtask

    task automatic test_clear();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b0, rnd64());
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 1'b1, rnd64());
        n_cmp++;
        if ({q, empty, full, usedw} !== {{WIDTH{1'b0}}, 1'b1, 1'b0, 8'd0}) begin
            n_bad++; $display("FAIL sclr_state: got q=%h e=%b f=%b u=%0d want q=0 e=1 f=0 u=0", q, empty, full, usedw);
        end
        w = rnd64();
        cycle(1'b0, 1'b1, 1'b0, w);
        cycle(1'b0, 1'b0, 1'b1, '0);
        n_cmp++;
        if (q !== w) begin
            n_bad++; $display("FAIL sclr_first_read: got %h want %h", q, w);
        end
        // Asynchronous reset between edges.
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b0, rnd64());
        #2;
        reset_n = 1'b0;
        mq.delete(); m_q = '0;
        #1;
        n_cmp++;
        if ({q, empty, full, usedw} !== {{WIDTH{1'b0}}, 1'b1, 1'b0, 8'd0}) begin
            n_bad++; $display("FAIL async_rst_state: got q=%h e=%b u=%0d want q=0 e=1 u=0", q, empty, usedw);
        end
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if ({q, empty, full, usedw} !== model_state()) begin
            n_bad++; $display("FAIL async_rst_hold: got q=%h e=%b u=%0d want q=0 e=1 u=0", q, empty, usedw);
        end
        w = rnd64();
        cycle(1'b0, 1'b1, 1'b0, w);
        cycle(1'b0, 1'b0, 1'b1, '0);
        n_cmp++;
        if (q !== w || empty !== 1'b1) begin
            n_bad++; $display("FAIL async_rst_first_read: got q=%h e=%b want q=%h e=1", q, empty, w);
        end
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_fill();
        test_boundary();
        test_wrap();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sc_fifo.md
Name: sc_fifo

Overview:
- Single-clock, first-in-first-out data buffer built on an internal RAM.
- Used to decouple the SDRAM read path from the LCD pixel path. Default instance is 64 bits wide and 256 words deep.
- Normal (non-showahead) read mode: a read request returns data on the next clock edge.
- Over/underflow protection is always on, and a synchronous clear is provided for frame restarts.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 256, number of storage words; must equal 2**WIDTHU.
- WIDTHU, 8, width of the usedw occupancy output and of the internal pointers.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sclr  input  1  synchronous clear, active high.
- data  input  WIDTH  write data.
- wrreq  input  1  write request.
- rdreq  input  1  read request.
- q  output  WIDTH  read data (registered).
- empty  output  1  high when the FIFO holds 0 words.
- full  output  1  high when the FIFO holds DEPTH words.
- usedw  output  WIDTHU  current word count modulo 2**WIDTHU.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Read pointer, write pointer and count become 0.
  - empty=1, full=0, usedw=0, q=0.
  - RAM contents are not cleared.
  - Outputs hold these values until the first rising edge after reset_n rises.
- Internal count has WIDTHU+1 bits, range 0..DEPTH.
  - empty = (count==0), full = (count==DEPTH); both are functions of the registered count.
  - usedw = count[WIDTHU-1:0], so usedw reads 0 when full; full disambiguates.
- Write:
  - On a rising edge with wrreq=1 and the write accepted, data is stored at the write pointer.
  - The write pointer increments and wraps from DEPTH-1 to 0.
- Read (normal mode):
  - On a rising edge with rdreq=1 and the read accepted, q is loaded with the word at the read pointer.
  - The read pointer then increments and wraps.
  - Data requested at edge N is visible on q after edge N, i.e. one clock latency from the sampled rdreq.
  - q holds its value when no read is accepted.
- Overflow checking:
  - wrreq while full=1 is ignored; nothing is stored and the pointer and count are unchanged.
  - This holds even if rdreq=1 on the same edge: the read proceeds, count decrements by 1, and the write is dropped.
- Underflow checking:
  - rdreq while empty=1 is ignored; q, the pointer and the count are unchanged.
  - This holds even if wrreq=1 on the same edge: the write proceeds and count becomes 1.
  - There is no write-to-read bypass; the new word is readable from the next edge.
- Simultaneous accepted read and write (0<count<DEPTH):
  - Both pointers advance and count is unchanged.
  - The read returns the oldest word, never the word being written.
- sclr:
  - On a rising edge with sclr=1: pointers and count go to 0, empty=1, full=0, q=0.
  - sclr has priority over wrreq and rdreq on the same edge; both are ignored.
  - Asynchronous reset has priority over everything.
- No combinational path from any input to any output: q, empty, full and usedw all change only on clock edges or asynchronous reset.
- Recommended RAM style: synchronous-read block RAM with an address-registered read port feeding q directly.

Test Plan:
- Reset then idle: hold reset_n low 3 cycles, release -> empty=1, full=0, usedw=0, q=0; rdreq pulses leave q=0 and usedw=0.
- Ordered transfer: write 0x11, 0x22, 0x33 on consecutive edges -> usedw=3, empty=0. Then one rdreq per cycle -> q=0x11, 0x22, 0x33 one edge after each request, after which usedw=0 and empty=1.
- Fill to full: write 256 distinct words (value = index) -> full=1, usedw=0. A 257th write with value 0xDEAD is dropped. Reading all 256 returns 0..255 in order, never 0xDEAD; empty=1 at the end.
- Boundary simultaneity:
  - When empty, assert wrreq+rdreq with data 0x5 -> q unchanged, usedw=1.
  - When full, assert wrreq+rdreq -> q=oldest word, usedw=255, full=0, and the written word is absent on later reads.
  - At count=10, wrreq+rdreq for 5 cycles -> usedw stays 10 and reads are in order.
- Pointer wrap: run 600 words through with occupancy held between 1 and 20 -> every read matches its write order.
- Clear mid-operation: with 100 words stored, pulse sclr together with wrreq and rdreq -> next edge gives empty=1, usedw=0, q=0. The next written word is the first one read back. Repeat the same check with reset_n asserted asynchronously between edges.
